// File: rtl/intc.sv
// intc: AHB-lite interrupt controller with level/edge sources, masking and fixed priority (index 0 highest).
// Define INTC_EDGE_DETECT_EN to build the TYPE register and edge latching; otherwise every source is level.
module intc #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        haddr,
  input  logic [31:0]        hwdata,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic               hsel,
  output logic [31:0]        hrdata,
  output logic               hready,
  output logic [1:0]         hresp,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_out,
  output logic [4:0]         irq_id
);

  localparam logic [7:0] ADDR_PEND   = 8'h00;
  localparam logic [7:0] ADDR_ENABLE = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CLAIM  = 8'h0C;
  localparam logic [7:0] ADDR_TYPE   = 8'h10;
  localparam logic [7:0] ADDR_GCTRL  = 8'h14;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] enable_q;
  logic               gctrl_q;
  logic               irqOut_q;
  logic [4:0]         irqId_q;

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] typeView;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] wrData;
  logic [7:0]         addr;
  logic               wrEn;
  logic               irqOut_d;
  logic [4:0]         irqId_d;
  logic [4:0]         firstId;

  // Only the low address byte and low data bits matter; size is ignored.
  logic unusedBits;
  assign unusedBits = ^{haddr[31:8], hsize, hwdata};

  assign addr   = haddr[7:0];
  assign wrEn   = hsel && hwrite;
  assign wrData = hwdata[NUM_SRC-1:0];

  assign hready = 1'b1;
  assign hresp  = 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      enable_q <= '0;
      gctrl_q  <= 1'b0;
    end else begin
      src_q <= irq_src;
      if (wrEn && addr == ADDR_ENABLE) enable_q <= wrData;
      if (wrEn && addr == ADDR_GCTRL)  gctrl_q  <= hwdata[0];
    end
  end

`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] type_q;
  logic [NUM_SRC-1:0] edgePend_q;
  logic [NUM_SRC-1:0] edgePend_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;

  // A fresh rising edge beats a simultaneous W1C; level bits keep the latch empty.
  assign rise       = irq_src & ~src_q;
  assign w1c        = (wrEn && addr == ADDR_PEND) ? wrData : '0;
  assign edgePend_d = type_q & ((edgePend_q & ~w1c) | rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q     <= '0;
      edgePend_q <= '0;
    end else begin
      edgePend_q <= edgePend_d;
      if (wrEn && addr == ADDR_TYPE) type_q <= wrData;
    end
  end

  assign typeView = type_q;
  assign pend     = (type_q & edgePend_q) | (~type_q & src_q);
`else
  assign typeView = '0;
  assign pend     = src_q;
`endif

  assign active   = pend & enable_q;
  assign irqOut_d = gctrl_q && (|active);

  always_comb begin
    firstId = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) firstId = 5'(i);
    end
  end

  assign irqId_d = irqOut_d ? firstId : 5'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqOut_q <= 1'b0;
      irqId_q  <= 5'd0;
    end else begin
      irqOut_q <= irqOut_d;
      irqId_q  <= irqId_d;
    end
  end

  assign irq_out = irqOut_q;
  assign irq_id  = irqId_q;

  always_comb begin
    hrdata = 32'd0;
    case (addr)
      ADDR_PEND:   hrdata = 32'(pend);
      ADDR_ENABLE: hrdata = 32'(enable_q);
      ADDR_STATUS: hrdata = 32'(active);
      ADDR_CLAIM:  hrdata = {irqOut_q, 26'd0, irqId_q};
      ADDR_TYPE:   hrdata = 32'(typeView);
      ADDR_GCTRL:  hrdata = {31'd0, gctrl_q};
      default:     hrdata = 32'd0;
    endcase
  end

endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 The parameter list SHALL be: NUM_SRC, 8, number of interrupt sources (1..32).
REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- haddr  input  32  AHB address; only [7:0] decoded.
- hwdata  input  32  AHB write data.
- hwrite  input  1  AHB write strobe.
- hsize  input  3  AHB size; ignored, all accesses are 32-bit.
- hsel  input  1  AHB slave select.
- hrdata  output  32  AHB read data.
- hready  output  1  AHB ready.
- hresp  output  2  AHB response.
- irq_src  input  NUM_SRC  interrupt sources, e.g. the timer irq on bit 0.
- irq_out  output  1  aggregated interrupt to the CPU.
- irq_id  output  5  index of the highest-priority active source.
REQ-003 The block SHALL use one clock, clk, and an asynchronous, active-low reset, rst_n.

Function
REQ-004 Register map on haddr[7:0]:
- 0x00 PEND: RO for level sources; W1C for edge sources.
- 0x04 ENABLE: RW mask.
- 0x08 STATUS: RO, PEND & ENABLE.
- 0x0C CLAIM: RO, bit31 = irq_out, [4:0] = irq_id.
- 0x10 TYPE: RW; 1 = edge, 0 = level.
- 0x14 GCTRL: RW; bit0 = global enable.
REQ-005 A write SHALL occur when hsel && hwrite and SHALL take effect at that rising clk edge.
REQ-006 hrdata SHALL be combinational from haddr[7:0].
REQ-007 Unmapped addresses SHALL read as 0, and writes to them SHALL be ignored.
REQ-008 Register bits at or above NUM_SRC SHALL read as 0 and ignore writes.
REQ-009 hready SHALL be constant 1 and hresp SHALL be constant 2'b00.
REQ-010 src_q SHALL be irq_src registered every cycle.
REQ-011 For a level source, PEND[i] SHALL equal src_q[i].
REQ-012 For an edge source, PEND[i] SHALL set at the clk edge where irq_src[i] && !src_q[i], and SHALL hold until cleared by W1C.
REQ-013 If a set and a W1C clear of the same edge bit occur in the same cycle, the set SHALL win.
REQ-014 A W1C write of 0 SHALL leave the bit unchanged.
REQ-015 W1C writes SHALL have no effect on level bits.
REQ-016 When TYPE[i] changes from 1 to 0, PEND[i] SHALL follow src_q[i] from the next cycle.
REQ-017 irq_out SHALL be registered as GCTRL[0] && |(PEND & ENABLE).
REQ-018 irq_id SHALL be registered as the lowest index i with PEND[i] && ENABLE[i] when irq_out's next value is 1, and 0 otherwise.
REQ-019 Latency SHALL be exactly 2 rising edges from irq_src[i] being sampled high to irq_out high (edge k sets PEND/src_q; edge k+1 sets irq_out), for both level and edge modes.
REQ-020 Deassertion SHALL follow the same path.
REQ-021 For a level source, irq_out SHALL fall 2 edges after irq_src[i] falls if no other source is active.
REQ-022 For an edge source, irq_out SHALL fall 1 edge after the W1C clear.
REQ-023 Clearing ENABLE[i] or GCTRL[0] SHALL deassert irq_out on the next edge, and PEND SHALL be unaffected.
REQ-024 Simultaneous sources SHALL resolve with fixed priority: index 0 highest.

Reset
REQ-025 While rst_n is low, src_q, PEND, ENABLE, TYPE, GCTRL, irq_out and irq_id SHALL be 0 immediately (asynchronous).
REQ-026 After reset, hrdata SHALL reflect these zero values.
REQ-027 Reset asserted mid-operation SHALL discard all pending edge interrupts.
REQ-028 The first edge after reset release SHALL sample irq_src into src_q; a source already high at release SHALL NOT produce an edge event.

Configuration
REQ-029 The macro INTC_EDGE_DETECT_EN SHALL select edge support.
- Defined: TYPE register and edge latching are implemented as above.
- Undefined: every source is level-sensitive, TYPE reads 0 and ignores writes, and PEND is read-only.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Level: ENABLE=0x01, GCTRL=1; irq_src[0] high at edge k -> irq_out=1 and CLAIM=0x8000_0000 after edge k+1; irq_src[0] low -> irq_out=0 two edges later.
- Edge (macro defined): TYPE=0x04, ENABLE=0x04; 1-cycle pulse on irq_src[2] -> PEND=0x04 held, irq_id=2; write PEND=0x04 -> irq_out=0 next edge.
- Priority: sources 5 and 3 active and enabled -> irq_id=3; W1C/drop source 3 -> irq_id=5.
- Set-vs-clear: new rising edge on irq_src[2] in the same cycle as W1C 0x04 -> PEND[2] stays 1.
- Masking: PEND=0x02 with ENABLE=0x00 -> irq_out=0 and STATUS=0; ENABLE=0x02 -> irq_out=1 one edge later; GCTRL=0 -> irq_out=0.
- Reset mid-operation: edge pending, rst_n pulsed low -> PEND, irq_out and all registers read 0; irq_src held high through release -> no edge pending.
